// File: rtl/pi_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// pi_rx_frame_ctrl
//   Receives frames from the Raspberry Pi over an 8-bit parallel bus. The link
//   uses a two-phase (toggle) handshake. The Pi places a byte on the bus and
//   then toggles its handshake level. The FPGA acknowledges by copying that
//   level onto fpga_hsk.
//
//   Each frame is a length byte followed by that many payload bytes. Only
//   payload bytes go into a first-word-fall-through FIFO, and each one is
//   tagged with a last-byte flag. While the FIFO is full the acknowledge is
//   withheld, which stalls the Pi.
//
//   Handshakes:
//     Pi side  - a byte is offered when the synchronised hsk level differs
//                from fpga_hsk. It is taken on the cycle we copy that level
//                onto fpga_hsk.
//     Consumer - strict valid/ready. The head word transfers on any rising
//                edge where m_valid && m_ready. m_data/m_last are only
//                meaningful while m_valid is high, and read as 0 otherwise.
//
// Ports
//   clk, reset    system clock; synchronous active-high reset
//   pi_hsk_raw    asynchronous Pi handshake level
//   pi_data_raw   Pi data bus, held stable around the toggle
//   fpga_hsk      acknowledge level (last accepted Pi level)
//   m_data        FIFO head payload byte
//   m_valid       FIFO not empty
//   m_last        head byte closes its frame
//   m_ready       consumer pop request
//   frame_err     one-cycle pulse: zero-length frame or inter-byte timeout
//   busy          high while a payload is being received (exposes FSM state)
// -----------------------------------------------------------------------------
module pi_rx_frame_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pi_hsk_raw,
    input  logic [7:0] pi_data_raw,
    output logic       fpga_hsk,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t        state_q,     state_d;
    logic          hsk_meta_q,  hsk_meta_d;
    logic          hsk_s_q,     hsk_s_d;
    logic [1:0]    sync_fill_q, sync_fill_d;
    logic [7:0]    data_r_q,    data_r_d;
    logic          armed_q,     armed_d;
    logic          fpga_hsk_q,  fpga_hsk_d;
    logic [7:0]    rem_q,       rem_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          frame_err_q, frame_err_d;
    logic [AW:0]   wr_ptr_q,    wr_ptr_d;
    logic [AW:0]   rd_ptr_q,    rd_ptr_d;

    logic [8:0]    fifo_mem_q [FIFO_DEPTH];

    logic          fifo_empty;
    logic          fifo_full;
    logic          event_pend;
    logic          accept;
    logic          push;
    logic          pop;
    logic [8:0]    push_data;
    logic [8:0]    head;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        event_pend = armed_q && (hsk_s_q != fpga_hsk_q);
        // A length byte never enters the FIFO, so only payload bytes wait for room.
        accept     = event_pend && ((state_q == ST_IDLE) || !fifo_full);
        pop        = !fifo_empty && m_ready;
        push_data  = {(rem_q == 8'd1), data_r_q};

        hsk_meta_d  = pi_hsk_raw;
        hsk_s_d     = hsk_meta_q;
        data_r_d    = pi_data_raw;
        // hsk_s only reflects the pin after two post-reset edges. Until then,
        // its reset value of 0 must not be mistaken for a Pi level of 0.
        sync_fill_d = {sync_fill_q[0], 1'b1};
        armed_d     = armed_q || ((sync_fill_q == 2'b11) && (hsk_s_q == fpga_hsk_q));
        fpga_hsk_d  = accept ? hsk_s_q : fpga_hsk_q;

        state_d     = state_q;
        rem_d       = rem_q;
        timer_d     = timer_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (data_r_q == 8'd0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        rem_d   = data_r_q;
                        timer_d = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    push    = 1'b1;
                    timer_d = '0;
                    if (rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                    end
                    if (rem_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end else if (event_pend) begin
                    // Stalled on a full FIFO: the Pi is not idle, so the timer holds.
                    timer_d = timer_q;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err_d = 1'b1;
                    rem_d       = 8'd0;
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hsk_meta_q  <= 1'b0;
            hsk_s_q     <= 1'b0;
            sync_fill_q <= 2'b00;
            data_r_q    <= 8'd0;
            armed_q     <= 1'b0;
            fpga_hsk_q  <= 1'b0;
            rem_q       <= 8'd0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            hsk_meta_q  <= hsk_meta_d;
            hsk_s_q     <= hsk_s_d;
            sync_fill_q <= sync_fill_d;
            data_r_q    <= data_r_d;
            armed_q     <= armed_d;
            fpga_hsk_q  <= fpga_hsk_d;
            rem_q       <= rem_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_comb begin
        head      = fifo_mem_q[rd_ptr_q[AW-1:0]];
        m_valid   = !fifo_empty;
        m_data    = fifo_empty ? 8'd0 : head[7:0];
        m_last    = fifo_empty ? 1'b0 : head[8];
        fpga_hsk  = fpga_hsk_q;
        frame_err = frame_err_q;
        busy      = (state_q == ST_PAYLOAD);
    end

endmodule

// File: tb/tb_pi_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pi_rx_frame_ctrl
//   Directed bench for pi_rx_frame_ctrl. Pi-side bytes are driven through a
//   toggle-handshake task. Payload words expected at the consumer are queued
//   in exp_q. A negedge monitor pops exp_q and compares it on every
//   m_valid && m_ready transfer.
// -----------------------------------------------------------------------------
module tb_pi_rx_frame_ctrl;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pi_hsk_raw = 1'b0;
    logic [7:0] pi_data_raw = 8'd0;
    logic       m_ready = 1'b0;
    logic       fpga_hsk;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    pi_rx_frame_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pi_hsk_raw (pi_hsk_raw),
        .pi_data_raw(pi_data_raw),
        .fpga_hsk   (fpga_hsk),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];
    logic       hsk_lvl = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Toggle the handshake with byte b. Return the number of rising edges until
    // the echo (0 = none within limit) and frame_err as seen at the echo.
    task automatic send_byte(input logic [7:0] b, input int limit,
                             output int lat, output logic err_seen);
        @(posedge clk); #2;
        pi_data_raw = b;
        hsk_lvl     = ~hsk_lvl;
        pi_hsk_raw  = hsk_lvl;
        lat         = 0;
        err_seen    = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (fpga_hsk == hsk_lvl) begin
                lat      = i;
                err_seen = frame_err;
                break;
            end
        end
    endtask

    // Byte that must be accepted with the nominal 3-edge echo latency.
    task automatic send_ok(input string tag, input logic [7:0] b);
        int   lat;
        logic err_seen;
        send_byte(b, 10, lat, err_seen);
        chk(tag, lat, 3);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            chk("rx_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("rx_word", {m_last, m_data}, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   lat;
        int   tmo_n;
        logic err_seen;

        // Reset state
        cycles(4);
        chk("rst_fpga_hsk", fpga_hsk, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        cycles(5);

        // 1: three-byte frame, streaming consumer
        m_ready = 1'b1;
        send_ok("t1_len_lat", 8'h03);
        chk("t1_busy", busy, 1);
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hB2});
        exp_q.push_back({1'b1, 8'hC3});
        send_ok("t1_b0_lat", 8'hA1);
        send_ok("t1_b1_lat", 8'hB2);
        send_ok("t1_b2_lat", 8'hC3);
        chk("t1_busy_end", busy, 0);
        wait_drain("t1_drain");

        // 2: zero-length frame
        send_byte(8'h00, 10, lat, err_seen);
        chk("t2_lat", lat, 3);
        chk("t2_err_pulse", err_seen, 1);
        chk("t2_busy", busy, 0);
        @(posedge clk); #1;
        chk("t2_err_width", frame_err, 0);
        chk("t2_m_valid", m_valid, 0);

        // 3: back-pressure, 20-byte frame into a 16-deep FIFO
        m_ready = 1'b0;
        send_ok("t3_len_lat", 8'h14);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == 19), 8'(8'h40 + i)});
            send_ok("t3_fill_lat", 8'(8'h40 + i));
        end
        exp_q.push_back({1'b0, 8'h50});
        send_byte(8'h50, 20, lat, err_seen);
        chk("t3_no_echo_full", lat, 0);
        chk("t3_busy_stall", busy, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (fpga_hsk == hsk_lvl) break;
            @(posedge clk); #1;
        end
        chk("t3_echo_resume", fpga_hsk, hsk_lvl);
        for (int i = 17; i < 20; i++) begin
            exp_q.push_back({(i == 19), 8'(8'h40 + i)});
            send_ok("t3_tail_lat", 8'(8'h40 + i));
        end
        chk("t3_busy_end", busy, 0);
        wait_drain("t3_drain");

        // 4: timeout after two of five payload bytes
        m_ready = 1'b0;
        send_ok("t4_len_lat", 8'h05);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        send_ok("t4_b0_lat", 8'h11);
        send_ok("t4_b1_lat", 8'h22);
        tmo_n = 0;
        for (int n = 1; n <= TMO + 20; n++) begin
            @(posedge clk); #1;
            if (frame_err) begin
                tmo_n = n;
                break;
            end
        end
        chk("t4_tmo_cycles", tmo_n, TMO);
        chk("t4_busy", busy, 0);
        chk("t4_m_valid", m_valid, 1);
        @(posedge clk); #1;
        chk("t4_err_width", frame_err, 0);
        m_ready = 1'b1;
        wait_drain("t4_drain");
        chk("t4_empty", m_valid, 0);
        send_ok("t4_new_len_lat", 8'h01);
        chk("t4_new_busy", busy, 1);
        exp_q.push_back({1'b1, 8'h77});
        send_ok("t4_new_b0_lat", 8'h77);
        chk("t4_new_busy_end", busy, 0);
        wait_drain("t4_new_drain");

        // 6: reset mid-payload with three bytes queued
        m_ready = 1'b0;
        send_ok("t6_len_lat", 8'h05);
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h03});
        send_ok("t6_b0_lat", 8'h01);
        send_ok("t6_b1_lat", 8'h02);
        send_ok("t6_b2_lat", 8'h03);
        chk("t6_pre_valid", m_valid, 1);
        @(posedge clk); #2;
        reset      = 1'b1;
        hsk_lvl    = 1'b0;
        pi_hsk_raw = 1'b0;
        @(posedge clk); #1;
        chk("t6_m_valid", m_valid, 0);
        chk("t6_fpga_hsk", fpga_hsk, 0);
        chk("t6_busy", busy, 0);
        chk("t6_frame_err", frame_err, 0);
        exp_q.delete();

        // 5: handshake held high through reset release
        hsk_lvl    = 1'b1;
        pi_hsk_raw = 1'b1;
        cycles(3);
        @(posedge clk); #2;
        reset = 1'b0;
        cycles(20);
        chk("t5_stuck_hsk", fpga_hsk, 0);
        chk("t5_stuck_busy", busy, 0);
        hsk_lvl    = 1'b0;
        pi_hsk_raw = 1'b0;
        cycles(6);
        chk("t5_low_hsk", fpga_hsk, 0);
        m_ready = 1'b1;
        send_ok("t5_len_lat", 8'h02);
        chk("t5_busy", busy, 1);
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b1, 8'h66});
        send_ok("t5_b0_lat", 8'h55);
        send_ok("t5_b1_lat", 8'h66);
        wait_drain("t5_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
